snn_neuron_scheduler: RTL and testbench
=======================================

SNN_NEURON_SCHEDULER -- requirements
Module: snn_neuron_scheduler

Interface
REQ-001 Parameter N_NEURONS, default 4: number of virtual neurons sharing one update datapath (2..16).
REQ-002 Parameter THRESH, default 8'd200: firing threshold.
REQ-003 Parameter LEAK_SHIFT, default 2: leak is v >> LEAK_SHIFT per timestep.
REQ-004 Parameter REFRAC_STEPS, default 3: refractory timesteps after a spike.
REQ-005 clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 tick  in  1  single-cycle pulse that starts one timestep sweep.
REQ-008 in_valid  in  1  input current strobe.
REQ-009 in_id  in  clog2(N_NEURONS)  target neuron of the input current.
REQ-010 in_current  in  8  unsigned input current.
REQ-011 in_ready  out  1  input accepted when in_valid && in_ready.
REQ-012 busy  out  1  high while a sweep is in progress.
REQ-013 spikes  out  N_NEURONS  spike vector of the last completed timestep.
REQ-014 spikes_valid  out  1  single-cycle pulse when spikes is updated.
REQ-015 tick_overrun  out  1  sticky flag; cleared only by reset.

Function
REQ-016 FSM states IDLE, UPDATE, DONE shall be used; IDLE->UPDATE on tick, UPDATE->DONE after neuron N_NEURONS-1 is updated, DONE->IDLE unconditionally.
REQ-017 In UPDATE, neuron index idx shall advance 0..N_NEURONS-1, one neuron per cycle; the sweep is N_NEURONS+1 cycles from tick to spikes_valid.
REQ-018 Per neuron: sum = v - (v >> LEAK_SHIFT) + acc[idx], computed 9 bits wide and saturated to 8'd255.
REQ-019 If sum >= THRESH: spike bit set, v cleared to 0; else v <= sum, spike bit clear.
REQ-020 acc[idx] shall be cleared when neuron idx is updated.
REQ-021 Accepted input shall add in_current to acc[in_id], saturating at 8'd255.
REQ-022 in_ready shall be 1 in every state; inputs are never back-pressured.
REQ-023 Input for neuron idx in the same cycle idx is updated shall load acc[idx] with in_current (counted next timestep), not be lost.
REQ-024 in_id >= N_NEURONS shall be accepted and discarded.
REQ-025 spikes shall be registered and presented together with spikes_valid in DONE, held until next DONE.
REQ-026 tick while busy or in DONE shall be ignored and set tick_overrun.
REQ-027 busy shall be high in UPDATE and DONE.

Reset
REQ-028 On rst_n low: state IDLE, idx 0, all v and acc 0, spikes 0, spikes_valid 0, busy 0, tick_overrun 0, refractory counters 0.
REQ-029 Reset asserted mid-sweep shall abort the sweep with no spikes_valid pulse.

Configuration
REQ-030 Macro SNN_REFRACTORY_EN defined: each spiking neuron loads a counter with REFRAC_STEPS; while the counter is nonzero its update discards acc, keeps v at 0, emits no spike, and decrements the counter.
REQ-031 Macro SNN_REFRACTORY_EN undefined: no refractory counters are built and a neuron may spike every timestep; REFRAC_STEPS is unused.

Structure
REQ-032 Package snn_pkg shall hold the FSM state enum, the 8-bit potential/current type and the saturating-add width constant.
REQ-033 Sub-module lif_update shall be combinational: (v, acc, refractory count) in, (v_next, spike, count_next) out; the scheduler instantiates exactly one.

Verification
REQ-034 Input id 1 current 250, tick -> after 5 cycles spikes_valid with spikes=4'b0010, v[1]=0.
REQ-035 Input id 0 current 100, ticks every 10 cycles -> v[0]: 100, 175, 232; spike on third timestep.
REQ-036 Two inputs of 200 to id 2 before tick -> acc saturates at 255, spikes[2]=1.
REQ-037 tick held for 2 consecutive cycles -> one sweep, tick_overrun=1.
REQ-038 With SNN_REFRACTORY_EN, id 3 current 250 every timestep -> spikes[3] pattern 1,0,0,0,1.
REQ-039 rst_n low during UPDATE of idx 2 -> no spikes_valid, all outputs at reset values one cycle later.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared types and helpers for the SNN neuron scheduler.
//   state_e : sweep FSM states
//   pot_t   : 8-bit membrane potential / input current
//   SumW    : width of the unsaturated add before clamping to 8 bits
//   sat_add : 8-bit add that clamps at 255
package snn_pkg;

  typedef enum logic [1:0] {StIdle, StUpdate, StDone} state_e;

  typedef logic [7:0] pot_t;

  localparam int unsigned SumW = 9;

  function automatic pot_t sat_add(input pot_t a, input pot_t b);
    logic [SumW-1:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[SumW-1] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/lif_update.sv
// Combinational leaky integrate-and-fire update for one neuron.
// Ports:
//   v          : current membrane potential
//   acc        : input current accumulated since the last update
//   count      : refractory steps remaining (tied to zero when refractoriness is not built)
//   v_next     : potential after this timestep
//   spike      : neuron fires this timestep
//   count_next : refractory count after this timestep
module lif_update
  import snn_pkg::*;
#(
  parameter pot_t        THRESH       = 8'd200,
  parameter int unsigned LEAK_SHIFT   = 2,
  parameter int unsigned REFRAC_STEPS = 3,
  parameter int unsigned CntW         = 2
) (
  input  pot_t            v,
  input  pot_t            acc,
  input  logic [CntW-1:0] count,
  output pot_t            v_next,
  output logic            spike,
  output logic [CntW-1:0] count_next
);

  logic [SumW-1:0] sum;
  pot_t            sum_sat;

  always_comb begin
    // v - (v >> k) can never underflow, so only the upper bound needs clamping.
    sum     = {1'b0, v} - {1'b0, v >> LEAK_SHIFT} + {1'b0, acc};
    sum_sat = sum[SumW-1] ? 8'hFF : sum[7:0];

    v_next     = sum_sat;
    spike      = 1'b0;
    count_next = '0;

    if (count != '0) begin
      // Refractory: input is dropped and the neuron stays silent at rest.
      v_next     = '0;
      count_next = count - CntW'(1);
    end else if (sum_sat >= THRESH) begin
      v_next     = '0;
      spike      = 1'b1;
      count_next = CntW'(REFRAC_STEPS);
    end
  end

endmodule

// File: rtl/snn_neuron_scheduler.sv
// Time-multiplexed LIF neuron array: N_NEURONS virtual neurons share one lif_update datapath.
// A tick pulse starts a sweep that updates one neuron per cycle, then presents the spike vector
// for one cycle in the DONE state.
// Optional feature: define SNN_REFRACTORY_EN to build per-neuron refractory counters.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   tick         : starts one timestep sweep (ignored and flagged while busy)
//   in_valid, in_id, in_current : input current strobe, target neuron, amount
//   in_ready     : always high, inputs are never back-pressured
//   busy         : sweep in progress (UPDATE or DONE)
//   spikes       : spike vector of the last completed timestep
//   spikes_valid : one-cycle pulse when spikes is updated
//   tick_overrun : sticky, set by a tick arriving while busy
module snn_neuron_scheduler
  import snn_pkg::*;
#(
  parameter int unsigned N_NEURONS    = 4,
  parameter logic [7:0]  THRESH       = 8'd200,
  parameter int unsigned LEAK_SHIFT   = 2,
  parameter int unsigned REFRAC_STEPS = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         tick,
  input  logic                         in_valid,
  input  logic [$clog2(N_NEURONS)-1:0] in_id,
  input  logic [7:0]                   in_current,
  output logic                         in_ready,
  output logic                         busy,
  output logic [N_NEURONS-1:0]         spikes,
  output logic                         spikes_valid,
  output logic                         tick_overrun
);

  localparam int unsigned IdW  = $clog2(N_NEURONS);
  localparam int unsigned CntW = (REFRAC_STEPS < 2) ? 1 : $clog2(REFRAC_STEPS + 1);
  localparam logic [IdW-1:0] LastIdx = IdW'(N_NEURONS - 1);

  state_e               state_q, state_d;
  logic [IdW-1:0]       idx_q, idx_d;
  logic [N_NEURONS-1:0] spk_work_q, spk_work_d;
  logic [N_NEURONS-1:0] spikes_q, spikes_d;
  logic                 overrun_q;
  pot_t                 v_q   [N_NEURONS];
  pot_t                 acc_q [N_NEURONS];

  pot_t            v_next;
  logic            spike_next;
  logic [CntW-1:0] cnt_cur, cnt_next;
  logic            updating, in_hit;

  assign updating = (state_q == StUpdate);
  // Out-of-range ids are accepted but land nowhere.
  assign in_hit   = in_valid && (32'(in_id) < N_NEURONS);

  lif_update #(
    .THRESH       (THRESH),
    .LEAK_SHIFT   (LEAK_SHIFT),
    .REFRAC_STEPS (REFRAC_STEPS),
    .CntW         (CntW)
  ) u_lif (
    .v          (v_q[idx_q]),
    .acc        (acc_q[idx_q]),
    .count      (cnt_cur),
    .v_next     (v_next),
    .spike      (spike_next),
    .count_next (cnt_next)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    spk_work_d = spk_work_q;
    spikes_d   = spikes_q;
    unique case (state_q)
      StIdle: begin
        if (tick) begin
          state_d    = StUpdate;
          idx_d      = '0;
          spk_work_d = '0;
        end
      end
      StUpdate: begin
        spk_work_d[idx_q] = spike_next;
        idx_d             = idx_q + IdW'(1);
        if (idx_q == LastIdx) begin
          state_d  = StDone;
          idx_d    = '0;
          spikes_d = spk_work_d;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      spk_work_q <= '0;
      spikes_q   <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      spk_work_q <= spk_work_d;
      spikes_q   <= spikes_d;
      if (tick && state_q != StIdle) overrun_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N_NEURONS); i++) begin
        v_q[i]   <= '0;
        acc_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(N_NEURONS); i++) begin
        if (updating && idx_q == IdW'(i)) begin
          v_q[i]   <= v_next;
          // Input colliding with this neuron's update starts the next timestep's sum.
          acc_q[i] <= (in_hit && in_id == IdW'(i)) ? in_current : '0;
        end else if (in_hit && in_id == IdW'(i)) begin
          acc_q[i] <= sat_add(acc_q[i], in_current);
        end
      end
    end
  end

`ifdef SNN_REFRACTORY_EN
  logic [CntW-1:0] ref_q [N_NEURONS];

  assign cnt_cur = ref_q[idx_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N_NEURONS); i++) ref_q[i] <= '0;
    end else if (updating) begin
      ref_q[idx_q] <= cnt_next;
    end
  end
`else
  logic unused_cnt;

  assign cnt_cur    = '0;
  assign unused_cnt = ^cnt_next;
`endif

  assign in_ready     = 1'b1;
  assign busy         = (state_q != StIdle);
  assign spikes       = spikes_q;
  assign spikes_valid = (state_q == StDone);
  assign tick_overrun = overrun_q;

endmodule

// File: tb/tb_snn_neuron_scheduler.sv
// Directed self-checking bench for snn_neuron_scheduler (default parameters, N_NEURONS = 4).
module tb_snn_neuron_scheduler;

  localparam int unsigned N = 4;

  logic         clk        = 1'b0;
  logic         rst_n      = 1'b0;
  logic         tick       = 1'b0;
  logic         in_valid   = 1'b0;
  logic [1:0]   in_id      = '0;
  logic [7:0]   in_current = '0;
  logic         in_ready, busy, spikes_valid, tick_overrun;
  logic [N-1:0] spikes;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  snn_neuron_scheduler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick         (tick),
    .in_valid     (in_valid),
    .in_id        (in_id),
    .in_current   (in_current),
    .in_ready     (in_ready),
    .busy         (busy),
    .spikes       (spikes),
    .spikes_valid (spikes_valid),
    .tick_overrun (tick_overrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // All tasks start and end #1 after a rising edge.
  task automatic do_reset();
    rst_n    = 1'b0;
    tick     = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic send(input logic [1:0] id, input logic [7:0] cur);
    in_valid   = 1'b1;
    in_id      = id;
    in_current = cur;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // One sweep; checks tick-to-spikes_valid latency and returns in IDLE.
  task automatic sweep(input string tag, output logic [N-1:0] spk);
    int n = 0;
    tick = 1'b1;
    @(posedge clk);
    #1 tick = 1'b0;
    while (!spikes_valid && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    check({tag, "_latency"}, n + 1, 5);
    spk = spikes;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [N-1:0] spk;
    logic [4:0]   refr_exp;
    int           pulses;

    // Reset state
    do_reset();
    check("rst_busy", busy, 0);
    check("rst_spikes", spikes, 0);
    check("rst_valid", spikes_valid, 0);
    check("rst_overrun", tick_overrun, 0);
    check("rst_in_ready", in_ready, 1);

    // Single strong input fires neuron 1
    send(2'd1, 8'd250);
    sweep("t1", spk);
    check("t1_spikes", spk, 4'b0010);
    check("t1_v1", dut.v_q[1], 0);
    check("t1_busy_after", busy, 0);
    check("t1_valid_after", spikes_valid, 0);
    check("t1_spikes_held", spikes, 4'b0010);

    // Leaky integration: 100, 175, then 232 fires
    do_reset();
    send(2'd0, 8'd100);
    sweep("t2a", spk);
    check("t2a_v0", dut.v_q[0], 100);
    check("t2a_spikes", spk, 4'b0000);
    send(2'd0, 8'd100);
    sweep("t2b", spk);
    check("t2b_v0", dut.v_q[0], 175);
    check("t2b_spikes", spk, 4'b0000);
    send(2'd0, 8'd100);
    sweep("t2c", spk);
    check("t2c_spikes", spk, 4'b0001);
    check("t2c_v0", dut.v_q[0], 0);

    // Accumulator saturation
    do_reset();
    send(2'd2, 8'd200);
    send(2'd2, 8'd200);
    check("t3_acc2", dut.acc_q[2], 255);
    sweep("t3", spk);
    check("t3_spikes", spk, 4'b0100);
    check("t3_acc2_cleared", dut.acc_q[2], 0);

    // Tick held two cycles: one sweep, overrun flagged
    do_reset();
    tick = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 tick = 1'b0;
    pulses = 0;
    repeat (15) begin
      if (spikes_valid) pulses++;
      @(posedge clk);
      #1;
    end
    check("t4_pulses", pulses, 1);
    check("t4_overrun", tick_overrun, 1);
    tick = 1'b1;
    @(posedge clk);
    #1 tick = 1'b0;
    check("t4_overrun_sticky", tick_overrun, 1);
    repeat (8) @(posedge clk);
    #1;

    // Input colliding with its own neuron's update carries to the next timestep
    do_reset();
    check("t5_overrun_cleared", tick_overrun, 0);
    tick = 1'b1;
    @(posedge clk);
    #1 tick = 1'b0;                // idx 0
    @(posedge clk);
    #1 in_valid = 1'b1;            // idx 1
    in_id      = 2'd1;
    in_current = 8'd250;
    check("t5_in_ready_busy", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    pulses = 0;
    while (!spikes_valid && pulses < 20) begin
      @(posedge clk);
      #1 pulses++;
    end
    check("t5_spikes_first", spikes, 4'b0000);
    check("t5_acc1", dut.acc_q[1], 250);
    @(posedge clk);
    #1;
    sweep("t5b", spk);
    check("t5b_spikes", spk, 4'b0010);

    // Reset during update of idx 2 aborts the sweep
    do_reset();
    send(2'd0, 8'd250);
    tick = 1'b1;
    @(posedge clk);
    #1 tick = 1'b0;                // idx 0
    @(posedge clk);
    #1;                            // idx 1
    @(posedge clk);
    #1 rst_n = 1'b0;               // idx 2
    #1;
    check("t6_valid", spikes_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_spikes", spikes, 0);
    check("t6_v0", dut.v_q[0], 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    pulses = 0;
    repeat (10) begin
      if (spikes_valid) pulses++;
      @(posedge clk);
      #1;
    end
    check("t6_no_pulse", pulses, 0);

    // Repeated strong input to neuron 3: refractory pattern or firing every step
`ifdef SNN_REFRACTORY_EN
    refr_exp = 5'b10001;
`else
    refr_exp = 5'b11111;
`endif
    do_reset();
    for (int t = 0; t < 5; t++) begin
      send(2'd3, 8'd250);
      sweep($sformatf("t7_%0d", t), spk);
      check($sformatf("t7_spike3_%0d", t), spk[3], refr_exp[4-t]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
